x_burst_driver: RTL and testbench

//  Tester-side command decoder driving N 23K640 SPI SRAM controller channels.

---
 rtl/x_burst_driver.sv | 142 ++++++++++++++
 tb/tb_x_burst_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/x_burst_driver.sv
// x_burst_driver: tester byte-command decoder driving single/burst accesses on N 23K640 SPI SRAM channels.
module x_burst_driver #(
  parameter int p_channels   = 16,
  parameter int p_addr_w     = 16,
  parameter int p_fifo_depth = 16,
  parameter int p_timeout    = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_test_valid,
  input  logic [7:0]              i_test_data,
  output logic                    o_test_valid,
  output logic [7:0]              o_test_data,
  output logic                    o_busy,
  output logic                    o_rd_n_wr,
  output logic [p_addr_w-1:0]     o_addr,
  output logic [7:0]              o_wdata,
  output logic [p_channels-1:0]   o_valid,
  input  logic [p_channels-1:0]   i_accept,
  input  logic [p_channels-1:0]   i_ready,
  input  logic [8*p_channels-1:0] i_rdata
);
  localparam int aw = $clog2(p_fifo_depth);
  localparam int tw = $clog2(p_timeout + 1);
  localparam logic [1:0] s_idle = 2'd0, s_req = 2'd1, s_rdwait = 2'd2;
  logic [1:0] state;
  logic [3:0] sel;
  logic [p_addr_w-1:0] addr;
  logic [7:0] wdata;
  logic rd_n_wr;
  logic [4:0] beats;
  logic [tw-1:0] tmo;
  logic [7:0] mem [p_fifo_depth];
  logic [aw-1:0] rp, wp;
  logic [aw:0] cnt;
  logic err_ovf, err_unf, err_tmo, err_busy, err_sel;
  logic [3:0] op, nib;
  logic busy, cfg, go, pop_cmd, stat_cmd, clr, sel_ok, acc, rdy, tmo_last;
  logic empty, full, push, do_pop, do_push;
  logic [15:0] acc16, rdy16;
  logic [127:0] rd128;
  logic [7:0] rbyte, status;
  assign op       = i_test_data[3:0];
  assign nib      = i_test_data[7:4];
  assign busy     = state != s_idle;
  assign cfg      = i_test_valid && (op == 4'd0 || op == 4'd1 || op == 4'd3 || op == 4'd4);
  assign go       = i_test_valid && (op == 4'd5 || op == 4'd8);
  assign pop_cmd  = i_test_valid && op == 4'd6;
  assign stat_cmd = i_test_valid && op == 4'd7;
  assign clr      = i_test_valid && op == 4'd9;
  assign sel_ok   = {1'b0, sel} < 5'(p_channels);
  // Widen channel buses so a 4-bit sel can index them for any channel count
  assign acc16    = 16'(i_accept);
  assign rdy16    = 16'(i_ready);
  assign rd128    = 128'(i_rdata);
  assign acc      = acc16[sel];
  assign rdy      = rdy16[sel];
  assign rbyte    = rd128[{sel, 3'b000} +: 8];
  assign tmo_last = tmo == tw'(p_timeout - 1);
  assign empty    = cnt == '0;
  assign full     = cnt == (aw + 1)'(p_fifo_depth);
  assign push     = state == s_rdwait && rdy;
  assign do_pop   = pop_cmd && !empty;
  assign do_push  = push && (!full || do_pop);
  assign status   = {busy, empty, full, err_ovf, err_unf, err_tmo, err_busy, err_sel};
  assign o_busy    = busy;
  assign o_rd_n_wr = rd_n_wr;
  assign o_addr    = addr;
  assign o_wdata   = wdata;
  for (genvar k = 0; k < p_channels; k++) begin : g_valid
    assign o_valid[k] = state == s_req && sel == 4'(k);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= s_idle;
      sel          <= '0;
      addr         <= '0;
      wdata        <= '0;
      rd_n_wr      <= 1'b0;
      beats        <= '0;
      tmo          <= '0;
      rp           <= '0;
      wp           <= '0;
      cnt          <= '0;
      err_ovf      <= 1'b0;
      err_unf      <= 1'b0;
      err_tmo      <= 1'b0;
      err_busy     <= 1'b0;
      err_sel      <= 1'b0;
      o_test_valid <= 1'b0;
      o_test_data  <= '0;
    end else begin
      if (cfg && !busy) begin
        if (op == 4'd0) sel <= nib;
        if (op == 4'd1) wdata <= {wdata[3:0], nib};
        if (op == 4'd3) addr <= (addr << 4) | p_addr_w'(nib);
        if (op == 4'd4) rd_n_wr <= nib[0];
      end
      if (state == s_idle && go && sel_ok) begin
        state <= s_req;
        beats <= op == 4'd8 ? {1'b0, nib} + 5'd1 : 5'd1;
        tmo   <= '0;
      end else if (state == s_req && acc) begin
        addr  <= addr + 1'b1;
        beats <= beats - 5'd1;
        tmo   <= '0;
        state <= rd_n_wr ? s_rdwait : (beats != 5'd1 ? s_req : s_idle);
      end else if (state == s_rdwait && rdy) begin
        tmo   <= '0;
        state <= beats != 5'd0 ? s_req : s_idle;
      end else if (busy && tmo_last) begin
        state   <= s_idle;
        err_tmo <= 1'b1;
      end else if (busy) begin
        tmo <= tmo + 1'b1;
      end
      if (busy && (cfg || go || clr)) err_busy <= 1'b1;
      if (!busy && go && !sel_ok) err_sel <= 1'b1;
      if (pop_cmd && empty) err_unf <= 1'b1;
      if (push && full && !do_pop) err_ovf <= 1'b1;
      o_test_valid <= pop_cmd || stat_cmd;
      if (pop_cmd || stat_cmd) o_test_data <= stat_cmd ? status : (empty ? 8'h00 : mem[rp]);
      if (clr && !busy) begin
        rp       <= '0;
        wp       <= '0;
        cnt      <= '0;
        err_ovf  <= 1'b0;
        err_unf  <= 1'b0;
        err_tmo  <= 1'b0;
        err_busy <= 1'b0;
        err_sel  <= 1'b0;
      end else begin
        if (do_push) wp <= wp + 1'b1;
        if (do_pop) rp <= rp + 1'b1;
        cnt <= cnt + {{aw{1'b0}}, do_push} - {{aw{1'b0}}, do_pop};
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wp] <= rbyte;
  end
endmodule

// File: tb/tb_x_burst_driver.sv
// tb_x_burst_driver: directed vector table plus hand sequences for timeout, rejection, overflow and reset.
module tb_x_burst_driver;
  localparam int nch = 8;
  localparam int tmo_cycles = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tv = 1'b0;
  logic [7:0] td = '0;
  logic o_tv, o_busy, o_rnw;
  logic [7:0] o_td, o_wd;
  logic [15:0] o_addr;
  logic [nch-1:0] o_valid, acc = '0, rdy = '0;
  logic [8*nch-1:0] rdata = '0;
  int total = 0, passed = 0;
  x_burst_driver #(.p_channels(nch), .p_addr_w(16), .p_fifo_depth(4), .p_timeout(tmo_cycles)) dut (
    .i_clk(clk), .i_rst(rst), .i_test_valid(tv), .i_test_data(td),
    .o_test_valid(o_tv), .o_test_data(o_td), .o_busy(o_busy), .o_rd_n_wr(o_rnw),
    .o_addr(o_addr), .o_wdata(o_wd), .o_valid(o_valid),
    .i_accept(acc), .i_ready(rdy), .i_rdata(rdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic tv; logic [7:0] td, acc, rdy, rd;
    logic [7:0] ov; logic busy; logic [15:0] addr; logic tval; logic [7:0] tdat;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic t, logic [7:0] d, logic [7:0] a, logic [7:0] r, logic [7:0] rb,
                              logic [7:0] ov, logic b, logic [15:0] ad, logic tval, logic [7:0] tdat);
    vec_t x;
    x.tv = t; x.td = d; x.acc = a; x.rdy = r; x.rd = rb;
    x.ov = ov; x.busy = b; x.addr = ad; x.tval = tval; x.tdat = tdat;
    return x;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  // channel 5 carries rb; every other channel carries a distractor byte
  task automatic drive(input logic t, input logic [7:0] d, input logic [7:0] a, input logic [7:0] r, input logic [7:0] rb);
    @(posedge clk);
    #1;
    tv = t; td = d; acc = a; rdy = r;
    rdata = {nch{8'hEE}};
    rdata[47:40] = rb;
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d);
    drive(1'b1, d, 8'h00, 8'h00, 8'h00);
  endtask
  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_wdata", 32'(o_wd), 0);
    chk("rst_tv", 32'(o_tv), 0);
    rst = 1'b0;
    // single write to ch2 at 1234 with data A5, accepted on the fourth request cycle
    v.push_back(mk(1, 8'h13, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0));
    v.push_back(mk(1, 8'h23, 0, 0, 0, 8'h00, 0, 16'h0001, 0, 0));
    v.push_back(mk(1, 8'h33, 0, 0, 0, 8'h00, 0, 16'h0012, 0, 0));
    v.push_back(mk(1, 8'h43, 0, 0, 0, 8'h00, 0, 16'h0123, 0, 0));
    v.push_back(mk(1, 8'hA1, 0, 0, 0, 8'h00, 0, 16'h1234, 0, 0));
    v.push_back(mk(1, 8'h51, 0, 0, 0, 8'h00, 0, 16'h1234, 0, 0));
    v.push_back(mk(1, 8'h04, 0, 0, 0, 8'h00, 0, 16'h1234, 0, 0));
    v.push_back(mk(1, 8'h20, 0, 0, 0, 8'h00, 0, 16'h1234, 0, 0));
    v.push_back(mk(1, 8'h05, 0, 0, 0, 8'h00, 0, 16'h1234, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h04, 1, 16'h1234, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h04, 1, 16'h1234, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h04, 1, 16'h1234, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h04, 0, 0, 8'h04, 1, 16'h1234, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 16'h1235, 0, 0));
    v.push_back(mk(1, 8'h07, 0, 0, 0, 8'h00, 0, 16'h1235, 0, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h1235, 1, 8'h40));
    // 4-beat read burst on ch5 from FFFE, wrapping through 0000
    v.push_back(mk(1, 8'hF3, 0, 0, 0, 8'h00, 0, 16'h1235, 0, 0));
    v.push_back(mk(1, 8'hF3, 0, 0, 0, 8'h00, 0, 16'h235F, 0, 0));
    v.push_back(mk(1, 8'hF3, 0, 0, 0, 8'h00, 0, 16'h35FF, 0, 0));
    v.push_back(mk(1, 8'hE3, 0, 0, 0, 8'h00, 0, 16'h5FFF, 0, 0));
    v.push_back(mk(1, 8'h14, 0, 0, 0, 8'h00, 0, 16'hFFFE, 0, 0));
    v.push_back(mk(1, 8'h50, 0, 0, 0, 8'h00, 0, 16'hFFFE, 0, 0));
    v.push_back(mk(1, 8'h38, 0, 0, 0, 8'h00, 0, 16'hFFFE, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h24, 8'h00, 8'h00, 8'h20, 1, 16'hFFFE, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 8'h20, 8'h11, 8'h00, 1, 16'hFFFF, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20, 1, 16'hFFFF, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 8'h04, 8'h99, 8'h00, 1, 16'h0000, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 8'h20, 8'h22, 8'h00, 1, 16'h0000, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 1, 16'h0000, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20, 1, 16'h0000, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 8'h20, 8'h33, 8'h00, 1, 16'h0001, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20, 1, 16'h0001, 0, 0));
    v.push_back(mk(0, 8'h00, 8'h00, 8'h20, 8'h44, 8'h00, 1, 16'h0002, 0, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0002, 0, 0));
    v.push_back(mk(1, 8'h06, 0, 0, 0, 8'h00, 0, 16'h0002, 0, 0));
    v.push_back(mk(1, 8'h06, 0, 0, 0, 8'h00, 0, 16'h0002, 1, 8'h11));
    v.push_back(mk(1, 8'h06, 0, 0, 0, 8'h00, 0, 16'h0002, 1, 8'h22));
    v.push_back(mk(1, 8'h06, 0, 0, 0, 8'h00, 0, 16'h0002, 1, 8'h33));
    v.push_back(mk(1, 8'h06, 0, 0, 0, 8'h00, 0, 16'h0002, 1, 8'h44));
    v.push_back(mk(1, 8'h07, 0, 0, 0, 8'h00, 0, 16'h0002, 1, 8'h00));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0002, 1, 8'h48));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0002, 0, 0));
    foreach (v[i]) begin
      drive(v[i].tv, v[i].td, v[i].acc, v[i].rdy, v[i].rd);
      chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(v[i].ov));
      chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'(v[i].busy));
      chk($sformatf("v%0d_addr", i), 32'(o_addr), 32'(v[i].addr));
      chk($sformatf("v%0d_tv", i), 32'(o_tv), 32'(v[i].tval));
      if (v[i].tval) chk($sformatf("v%0d_tdata", i), 32'(o_td), 32'(v[i].tdat));
    end
    chk("wdata", 32'(o_wd), 32'h A5);
    chk("rd_n_wr", 32'(o_rnw), 1);
    // request timeout with accept held low
    send(8'h09);
    send(8'h05);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      idle();
      if (o_valid == '0) break;
      n++;
    end
    chk("tmo_len", 32'(n), 32'(tmo_cycles));
    chk("tmo_busy", 32'(o_busy), 0);
    send(8'h07);
    idle();
    chk("tmo_stat", 32'(o_td), 32'h44);
    send(8'h09);
    send(8'h07);
    idle();
    chk("clr_stat", 32'(o_td), 32'h40);
    // out-of-range channel, then config while busy
    send(8'hF0);
    send(8'h05);
    idle();
    chk("sel_valid", 32'(o_valid), 0);
    chk("sel_busy", 32'(o_busy), 0);
    send(8'h07);
    idle();
    chk("sel_stat", 32'(o_td), 32'h41);
    send(8'h09);
    send(8'h50);
    send(8'h18);
    send(8'h73);
    chk("busy_valid", 32'(o_valid), 32'h20);
    send(8'h07);
    chk("busy_addr", 32'(o_addr), 32'h0002);
    idle();
    chk("busy_stat", 32'(o_td), 32'hC2);
    for (int i = 0; i < 50 && o_busy; i++) idle();
    chk("busy_end", 32'(o_busy), 0);
    send(8'h09);
    // 6-beat read into a 4-deep FIFO; last push coincides with a POP
    send(8'h58);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 8'h20, 8'h00, 8'h00);
      drive(i == 5, 8'h06, 8'h00, 8'h20, 8'(8'hA0 + i));
    end
    send(8'h07);
    chk("ovf_pop0", 32'(o_td), 32'hA0);
    idle();
    chk("ovf_stat", 32'(o_td), 32'h30);
    send(8'h06);
    send(8'h06);
    chk("ovf_pop1", 32'(o_td), 32'hA1);
    send(8'h06);
    chk("ovf_pop2", 32'(o_td), 32'hA2);
    send(8'h06);
    chk("ovf_pop3", 32'(o_td), 32'hA3);
    idle();
    chk("ovf_pop4", 32'(o_td), 32'hA5);
    // reset during the second beat of a write burst
    send(8'h04);
    send(8'h20);
    send(8'h38);
    drive(1'b0, 8'h00, 8'h04, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("mid_valid", 32'(o_valid), 32'h04);
    rst = 1'b1;
    tv = 1'b1;
    td = 8'h07;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tv = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_addr", 32'(o_addr), 0);
    chk("mrst_wdata", 32'(o_wd), 0);
    chk("mrst_tv", 32'(o_tv), 0);
    send(8'h07);
    idle();
    chk("mrst_stat", 32'(o_td), 32'h40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
